// File: rtl/barrel_shift_pipe.sv
// -----------------------------------------------------------------------------
// barrel_shift_pipe
//
// Two-stage pipelined barrel shifter for the execute stage. It supports
// logical left/right, arithmetic right, and rotate left/right operations, with
// a valid/ready handshake on both the input and output sides.
//
// Datapath: there are log2(WIDTH) mux levels. Level k shifts by 2**k when
// shamt[k] is set.
//   - Stage 1 evaluates levels 0 .. SHW/2-1. It registers the partial result
//     together with the operation controls and the upper shamt bits.
//   - Stage 2 evaluates the remaining levels and registers Y.
// Right shifts use the same level structure, but shift toward bit 0.
//
// Optional feature: define BSH_FLAGS_EN to add the out_zero and out_carry
// ports. Their registers are created only when the feature is enabled.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high reset
//   in_valid   in   input operation valid
//   in_ready   out  input can be accepted this cycle (combinational)
//   FS         in   function select (SLL 0C, SRL 0D, SRA 0E, ROL 1A, ROR 1B)
//   T          in   operand
//   shamt      in   shift amount
//   out_valid  out  result valid
//   out_ready  in   downstream accepts result
//   Y          out  result (0 for unknown FS)
//   out_zero   out  (BSH_FLAGS_EN) Y == 0
//   out_carry  out  (BSH_FLAGS_EN) last bit shifted/rotated out
// -----------------------------------------------------------------------------
module barrel_shift_pipe #(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       FS,
    input  logic [WIDTH-1:0] T,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y
`ifdef BSH_FLAGS_EN
    ,
    output logic             out_zero,
    output logic             out_carry
`endif
);

    localparam int LV1 = SHW / 2;     // levels evaluated in stage 1
    localparam int LV2 = SHW - LV1;   // levels evaluated in stage 2

    localparam logic [4:0] FS_SLL = 5'h0C;
    localparam logic [4:0] FS_SRL = 5'h0D;
    localparam logic [4:0] FS_SRA = 5'h0E;
    localparam logic [4:0] FS_ROL = 5'h1A;
    localparam logic [4:0] FS_ROR = 5'h1B;

    // One mux level: shift by 2**k when en is set.
    // A rotate wraps the bits that fall off the end back into the vacated
    // positions. A right shift fills the vacated top bits with the fill bit.
    function automatic logic [WIDTH-1:0] shift_level(
        input logic [WIDTH-1:0] d,
        input logic             en,
        input int               k,
        input logic             left,
        input logic             rot,
        input logic             fill
    );
        int               amt;
        logic [WIDTH-1:0] ones;
        logic [WIDTH-1:0] r;
        amt  = 1 << k;
        ones = '1;
        if (!en) begin
            r = d;
        end else if (left) begin
            r = (d << amt) | (rot ? (d >> (WIDTH - amt)) : '0);
        end else begin
            r = (d >> amt) | (rot ? (d << (WIDTH - amt))
                                  : (fill ? ~(ones >> amt) : '0));
        end
        return r;
    endfunction

    // ---------------- handshake ----------------
    logic s1_valid_q, s1_valid_d;
    logic out_valid_q, out_valid_d;
    logic s1_adv, s2_adv;

    assign s2_adv   = !out_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;

    // ---------------- decode ----------------
    logic op_known, op_left, op_rot, op_sra, op_fill;

    always_comb begin
        op_known = 1'b1;
        op_left  = 1'b0;
        op_rot   = 1'b0;
        op_sra   = 1'b0;
        case (FS)
            FS_SLL:  op_left = 1'b1;
            FS_SRL:  ;
            FS_SRA:  op_sra = 1'b1;
            FS_ROL:  begin op_left = 1'b1; op_rot = 1'b1; end
            FS_ROR:  op_rot = 1'b1;
            default: op_known = 1'b0;
        endcase
    end

    assign op_fill = op_sra & T[WIDTH-1];

    // ---------------- stage 1 levels ----------------
    // An unknown FS zeroes the operand at the entry point. Every level then
    // passes zeros through, so Y = 0 needs no special case later on.
    logic [WIDTH-1:0] lvl1 [LV1+1];
    assign lvl1[0] = op_known ? T : '0;

    genvar gi;
    generate
        for (gi = 0; gi < LV1; gi++) begin : g_stage1
            assign lvl1[gi+1] = shift_level(lvl1[gi], shamt[gi], gi,
                                            op_left, op_rot, op_fill);
        end
    endgenerate

    // ---------------- stage 1 registers ----------------
    logic [WIDTH-1:0] data1_q, data1_d;
    logic [LV2-1:0]   shamt_hi_q, shamt_hi_d;
    logic             left1_q, left1_d;
    logic             rot1_q, rot1_d;
    logic             fill1_q, fill1_d;

`ifdef BSH_FLAGS_EN
    // The carry is taken from the original operand.
    // Left ops: T[WIDTH-shamt], computed as T[-shamt] modulo WIDTH.
    // Right ops: T[shamt-1].
    logic [SHW-1:0] shamt_neg, shamt_m1;
    logic           carry_in;
    logic           carry1_q, carry1_d;

    assign shamt_neg = '0 - shamt;
    assign shamt_m1  = shamt - SHW'(1);
    assign carry_in  = (shamt == '0 || !op_known) ? 1'b0 :
                       (op_left ? T[shamt_neg] : T[shamt_m1]);
`endif

    // ---------------- stage 2 levels ----------------
    logic [WIDTH-1:0] lvl2 [LV2+1];
    assign lvl2[0] = data1_q;

    generate
        for (gi = 0; gi < LV2; gi++) begin : g_stage2
            assign lvl2[gi+1] = shift_level(lvl2[gi], shamt_hi_q[gi], gi + LV1,
                                            left1_q, rot1_q, fill1_q);
        end
    endgenerate

    // ---------------- stage 2 registers ----------------
    logic [WIDTH-1:0] y_q, y_d;
`ifdef BSH_FLAGS_EN
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
`endif

    always_comb begin
        // By default every stage holds its contents.
        s1_valid_d  = s1_valid_q;
        data1_d     = data1_q;
        shamt_hi_d  = shamt_hi_q;
        left1_d     = left1_q;
        rot1_d      = rot1_q;
        fill1_d     = fill1_q;
        out_valid_d = out_valid_q;
        y_d         = y_q;
`ifdef BSH_FLAGS_EN
        carry1_d    = carry1_q;
        zero_d      = zero_q;
        carry_d     = carry_q;
`endif
        if (s1_adv) begin
            s1_valid_d = in_valid;
            data1_d    = lvl1[LV1];
            shamt_hi_d = shamt[SHW-1:LV1];
            left1_d    = op_left;
            rot1_d     = op_rot;
            fill1_d    = op_fill;
`ifdef BSH_FLAGS_EN
            carry1_d   = carry_in;
`endif
        end
        if (s2_adv) begin
            out_valid_d = s1_valid_q;
            y_d         = lvl2[LV2];
`ifdef BSH_FLAGS_EN
            zero_d      = (lvl2[LV2] == '0);
            carry_d     = carry1_q;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            data1_q     <= '0;
            shamt_hi_q  <= '0;
            left1_q     <= 1'b0;
            rot1_q      <= 1'b0;
            fill1_q     <= 1'b0;
            out_valid_q <= 1'b0;
            y_q         <= '0;
`ifdef BSH_FLAGS_EN
            carry1_q    <= 1'b0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
`endif
        end else begin
            s1_valid_q  <= s1_valid_d;
            data1_q     <= data1_d;
            shamt_hi_q  <= shamt_hi_d;
            left1_q     <= left1_d;
            rot1_q      <= rot1_d;
            fill1_q     <= fill1_d;
            out_valid_q <= out_valid_d;
            y_q         <= y_d;
`ifdef BSH_FLAGS_EN
            carry1_q    <= carry1_d;
            zero_q      <= zero_d;
            carry_q     <= carry_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign Y         = y_q;
`ifdef BSH_FLAGS_EN
    assign out_zero  = zero_q;
    assign out_carry = carry_q;
`endif

endmodule
